clusterv_tile_sram_arbiter: RTL and testbench
=============================================

# clusterv_tile_sram_arbiter

Two-initiator arbiter that shares one tile SRAM byte-enable target port (the 1 KiB 32x256 RW port of the tile SRAM macro) between the core load/store path (initiator 0) and the tile DMA/debug path (initiator 1). It accepts one request per cycle and drives the single SRAM command, with fair round-robin or fixed-priority selection. It tracks the owner of each read and returns the SRAM's one-cycle-late read data to that owner with a valid strobe. It sits between the tile interconnect and the tile SRAM wrapper.

## Interface
- ADDR_WIDTH, 8, word address width
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- iN_req  in  1  request valid (N = 0,1); held with fields stable until iN_gnt
- iN_we  in  1  1 = write, 0 = read
- iN_addr  in  ADDR_WIDTH  word address
- iN_byte_en  in  DATA_WIDTH/8  write byte mask
- iN_write_data  in  DATA_WIDTH  write data
- iN_gnt  out  1  request accepted this cycle (combinational)
- iN_rvalid  out  1  read data valid for initiator N (registered)
- iN_read_data  out  DATA_WIDTH  read data, meaningful only when iN_rvalid
- t_addr, t_read_en, t_write_en, t_byte_en, t_write_data  out  -  SRAM target command, widths per parameters
- t_read_data  in  DATA_WIDTH  SRAM read data, valid one cycle after t_read_en

## Operation
- At most one grant per cycle; a grant is issued only when the corresponding req is high and reset is low.
- Only one requester: it is granted every cycle it requests, back-to-back, with no bubbles.
- Both requesting: the winner is chosen by the selection policy (see Configuration).
- Grant to N:
  - t_addr, t_byte_en and t_write_data take the fields of N.
  - t_write_en = iN_we.
  - t_read_en = ~iN_we.
- No grant: all t_* outputs are 0.
- Read tracking: on a granted read, register rd_pend=1 and rd_owner=N. Next cycle, iN_rvalid = rd_pend & (rd_owner==N).
- iN_read_data = t_read_data for both initiators (unqualified fan-out); initiators must qualify it with rvalid.
- Writes produce no response; iN_gnt is the completion.
- No outstanding limit beyond one read per cycle, since the SRAM is fully pipelined.
- Write to address A at cycle k, then read of A at cycle k+1: the read returns the new data (SRAM ordering). The arbiter adds no reordering.
- Reset:
  - iN_gnt = 0.
  - iN_rvalid = 0; rd_pend is cleared.
  - The priority pointer resets to initiator 0 preferred.
  - A read granted in the cycle before reset asserts does not produce rvalid.

## Timing
- Cycle c: req and gnt are both high, and the SRAM command is presented.
- Cycle c+1: rvalid and read_data are valid for a read. Read latency is 1 cycle from grant.
- The request-to-grant path is combinational; the arbiter has no request-side registers.
- Throughput is 1 access/cycle total. With both initiators continuously requesting under round-robin, each gets 1 access every 2 cycles.
- rvalid is high for exactly one cycle per granted read.

## Configuration
- CLUSTERV_TILE_SRAM_ARB_RR_EN defined (round-robin):
  - A last-grant register, reset value 1, records the last granted initiator and updates only on a grant.
  - On contention, the initiator not granted last wins.
- CLUSTERV_TILE_SRAM_ARB_RR_EN not defined (fixed priority):
  - Initiator 0 always wins on contention.
  - The pointer register is absent. Initiator 1 may starve; this is accepted.

## Test plan
- Reset with both reqs high: gnt0 = gnt1 = 0 and rvalid = 0 throughout reset. In the first cycle after reset, gnt0 = 1.
- i0 writes 0xDEADBEEF to address 0x10 with byte_en 0xF, then reads 0x10 in the next cycle: t_write_en = 1 in cycle c, t_read_en = 1 in cycle c+1, and i0_rvalid = 1 with i0_read_data = 0xDEADBEEF in cycle c+2.
- Byte write: write byte_en 0x2 with data 0x0000AB00 over 0xDEADBEEF at address 0x10, then read it back: returns 0xDEADABEF.
- Both initiators issue continuous reads to addresses 0x01 and 0x02:
  - With RR_EN: grants alternate 0, 1, 0, 1, and the rvalids alternate one cycle later, each with the correct data.
  - Without RR_EN: gnt1 never asserts.
- i1 read granted in cycle c, reset asserted in cycle c+1: i1_rvalid stays 0, and no spurious rvalid appears after reset deasserts.
- Single requester i1 issues 8 back-to-back reads: gnt1 is high for 8 consecutive cycles and i1_rvalid is high for 8 consecutive cycles, delayed by 1.

Source files
------------

// File: rtl/clusterv_tile_sram_arbiter.sv
// ---------------------------------------------------------------------------
// clusterv_tile_sram_arbiter
//
// Shares the single byte-enable RW port of the tile SRAM between the core
// load/store path (initiator 0) and the tile DMA/debug path (initiator 1).
// One access is granted per cycle. The grant is a combinational function of
// the requests. Reads return one cycle later and are steered back to their
// owner with an rvalid strobe.
//
// Build option:
//   CLUSTERV_TILE_SRAM_ARB_RR_EN defined   -> round-robin on contention
//   CLUSTERV_TILE_SRAM_ARB_RR_EN undefined -> initiator 0 always wins
//
// Ports:
//   clock_i, reset_i            clock, synchronous active-high reset
//   iN_req_i / iN_we_i          request valid / write (1) or read (0)
//   iN_addr_i                   word address
//   iN_byte_en_i                write byte mask
//   iN_write_data_i             write data
//   iN_gnt_o                    request accepted this cycle (combinational)
//   iN_rvalid_o                 read data valid for initiator N
//   iN_read_data_o              SRAM read data, qualify with iN_rvalid_o
//   t_*_o                       SRAM command, all zero when nothing is granted
//   t_read_data_i               SRAM read data, one cycle after t_read_en_o
// ---------------------------------------------------------------------------
module clusterv_tile_sram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clock_i,
    input  logic                  reset_i,

    input  logic                  i0_req_i,
    input  logic                  i0_we_i,
    input  logic [ADDR_WIDTH-1:0] i0_addr_i,
    input  logic [BE_WIDTH-1:0]   i0_byte_en_i,
    input  logic [DATA_WIDTH-1:0] i0_write_data_i,
    output logic                  i0_gnt_o,
    output logic                  i0_rvalid_o,
    output logic [DATA_WIDTH-1:0] i0_read_data_o,

    input  logic                  i1_req_i,
    input  logic                  i1_we_i,
    input  logic [ADDR_WIDTH-1:0] i1_addr_i,
    input  logic [BE_WIDTH-1:0]   i1_byte_en_i,
    input  logic [DATA_WIDTH-1:0] i1_write_data_i,
    output logic                  i1_gnt_o,
    output logic                  i1_rvalid_o,
    output logic [DATA_WIDTH-1:0] i1_read_data_o,

    output logic [ADDR_WIDTH-1:0] t_addr_o,
    output logic                  t_read_en_o,
    output logic                  t_write_en_o,
    output logic [BE_WIDTH-1:0]   t_byte_en_o,
    output logic [DATA_WIDTH-1:0] t_write_data_o,
    input  logic [DATA_WIDTH-1:0] t_read_data_i
);

    logic rd_pend_q, rd_pend_d;
    logic rd_owner_q, rd_owner_d;
    logic prefer1;

`ifdef CLUSTERV_TILE_SRAM_ARB_RR_EN
    // Last granted initiator; resets to 1 so initiator 0 is preferred first.
    logic last_q, last_d;

    assign prefer1 = ~last_q;

    always_comb begin
        last_d = last_q;
        if (i0_gnt_o || i1_gnt_o) begin
            last_d = i1_gnt_o;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign prefer1 = 1'b0;
`endif

    always_comb begin
        i0_gnt_o       = 1'b0;
        i1_gnt_o       = 1'b0;
        t_addr_o       = '0;
        t_read_en_o    = 1'b0;
        t_write_en_o   = 1'b0;
        t_byte_en_o    = '0;
        t_write_data_o = '0;
        rd_pend_d      = 1'b0;
        rd_owner_d     = rd_owner_q;

        if (!reset_i) begin
            i0_gnt_o = i0_req_i & (~i1_req_i | ~prefer1);
            i1_gnt_o = i1_req_i & (~i0_req_i |  prefer1);
        end

        if (i0_gnt_o) begin
            t_addr_o       = i0_addr_i;
            t_read_en_o    = ~i0_we_i;
            t_write_en_o   = i0_we_i;
            t_byte_en_o    = i0_byte_en_i;
            t_write_data_o = i0_write_data_i;
            rd_pend_d      = ~i0_we_i;
            rd_owner_d     = 1'b0;
        end else if (i1_gnt_o) begin
            t_addr_o       = i1_addr_i;
            t_read_en_o    = ~i1_we_i;
            t_write_en_o   = i1_we_i;
            t_byte_en_o    = i1_byte_en_i;
            t_write_data_o = i1_write_data_i;
            rd_pend_d      = ~i1_we_i;
            rd_owner_d     = 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Gating with reset drops a read granted just before reset asserts.
    assign i0_rvalid_o = ~reset_i & rd_pend_q & ~rd_owner_q;
    assign i1_rvalid_o = ~reset_i & rd_pend_q &  rd_owner_q;

    assign i0_read_data_o = t_read_data_i;
    assign i1_read_data_o = t_read_data_i;

endmodule

// File: tb/tb_clusterv_tile_sram_arbiter.sv
module tb_clusterv_tile_sram_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    typedef struct packed {
        logic          req;
        logic          we;
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] wd;
    } req_t;

    typedef struct {
        req_t          q0;
        req_t          q1;
        logic          eg0;
        logic          eg1;
        logic          ewe;
        logic          ere;
        logic [AW-1:0] eaddr;
        logic          erv0;
        logic          erv1;
        logic [DW-1:0] erd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          r0, w0, r1, w1;
    logic [AW-1:0] a0, a1;
    logic [BW-1:0] b0, b1;
    logic [DW-1:0] d0, d1;
    logic          g0, g1, rv0, rv1;
    logic [DW-1:0] rd0, rd1;
    logic [AW-1:0] t_addr;
    logic          t_re, t_we;
    logic [BW-1:0] t_be;
    logic [DW-1:0] t_wd;
    logic [DW-1:0] sram_rd;

    logic [DW-1:0] mem    [256];
    logic [DW-1:0] shadow [256];

    int n_pass = 0;
    int n_tot  = 0;

    clusterv_tile_sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock_i(clk), .reset_i(rst),
        .i0_req_i(r0), .i0_we_i(w0), .i0_addr_i(a0), .i0_byte_en_i(b0),
        .i0_write_data_i(d0), .i0_gnt_o(g0), .i0_rvalid_o(rv0), .i0_read_data_o(rd0),
        .i1_req_i(r1), .i1_we_i(w1), .i1_addr_i(a1), .i1_byte_en_i(b1),
        .i1_write_data_i(d1), .i1_gnt_o(g1), .i1_rvalid_o(rv1), .i1_read_data_o(rd1),
        .t_addr_o(t_addr), .t_read_en_o(t_re), .t_write_en_o(t_we),
        .t_byte_en_o(t_be), .t_write_data_o(t_wd), .t_read_data_i(sram_rd)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] nw,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < BW; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // Behavioural tile SRAM: one-cycle read latency, byte-masked writes.
    always @(posedge clk) begin
        if (t_we) mem[t_addr] <= merge(mem[t_addr], t_wd, t_be);
        if (t_re) sram_rd <= mem[t_addr];
    end

    function automatic req_t mk(input logic we, input logic [AW-1:0] addr,
                                input logic [BW-1:0] be, input logic [DW-1:0] wd);
        req_t q;
        q.req = 1'b1; q.we = we; q.addr = addr; q.be = be; q.wd = wd;
        return q;
    endfunction

    task automatic apply(input req_t q0, input req_t q1);
        r0 = q0.req; w0 = q0.we; a0 = q0.addr; b0 = q0.be; d0 = q0.wd;
        r1 = q1.req; w1 = q1.we; a1 = q1.addr; b1 = q1.be; d1 = q1.wd;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [11];
    localparam req_t IDLE = '0;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req_t p0, p1, sel;
        logic last_m, resp_v, resp_own, eg0, eg1, pref0;
        logic [DW-1:0] resp_d;
        int prev;

        //            q0                                q1                            g0 g1 we re addr  rv0 rv1 rdata
        vecs[0]  = '{mk(1, 8'h10, 4'hF, 32'hDEADBEEF), IDLE,                          1, 0, 1, 0, 8'h10, 0, 0, 32'h0};
        vecs[1]  = '{mk(0, 8'h10, 4'h0, 32'h0),        IDLE,                          1, 0, 0, 1, 8'h10, 0, 0, 32'h0};
        vecs[2]  = '{mk(1, 8'h10, 4'h2, 32'h0000AB00), IDLE,                          1, 0, 1, 0, 8'h10, 1, 0, 32'hDEADBEEF};
        vecs[3]  = '{mk(0, 8'h10, 4'h0, 32'h0),        IDLE,                          1, 0, 0, 1, 8'h10, 0, 0, 32'h0};
        vecs[4]  = '{IDLE,                             IDLE,                          0, 0, 0, 0, 8'h00, 1, 0, 32'hDEADABEF};
        vecs[5]  = '{IDLE,                             mk(1, 8'h02, 4'hF, 32'h12345678), 0, 1, 1, 0, 8'h02, 0, 0, 32'h0};
        vecs[6]  = '{IDLE,                             mk(0, 8'h02, 4'h0, 32'h0),     0, 1, 0, 1, 8'h02, 0, 0, 32'h0};
        vecs[7]  = '{IDLE,                             IDLE,                          0, 0, 0, 0, 8'h00, 0, 1, 32'h12345678};
        vecs[8]  = '{IDLE,                             mk(1, 8'h01, 4'hF, 32'h000000AA), 0, 1, 1, 0, 8'h01, 0, 0, 32'h0};
        vecs[9]  = '{mk(0, 8'h01, 4'h0, 32'h0),        IDLE,                          1, 0, 0, 1, 8'h01, 0, 0, 32'h0};
        vecs[10] = '{IDLE,                             IDLE,                          0, 0, 0, 0, 8'h00, 1, 0, 32'h000000AA};

        apply(IDLE, IDLE);
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Directed table.
        foreach (vecs[i]) begin
            step();
            apply(vecs[i].q0, vecs[i].q1);
            @(negedge clk);
            chk($sformatf("tbl%0d gnt0", i), g0, vecs[i].eg0);
            chk($sformatf("tbl%0d gnt1", i), g1, vecs[i].eg1);
            chk($sformatf("tbl%0d t_we", i), t_we, vecs[i].ewe);
            chk($sformatf("tbl%0d t_re", i), t_re, vecs[i].ere);
            chk($sformatf("tbl%0d t_addr", i), t_addr, vecs[i].eaddr);
            chk($sformatf("tbl%0d rvalid0", i), rv0, vecs[i].erv0);
            chk($sformatf("tbl%0d rvalid1", i), rv1, vecs[i].erv1);
            if (vecs[i].erv0) chk($sformatf("tbl%0d rdata0", i), rd0, vecs[i].erd);
            if (vecs[i].erv1) chk($sformatf("tbl%0d rdata1", i), rd1, vecs[i].erd);
        end

        // Reset with both requesting, then contention on reads of 0x01 / 0x02.
        step();
        rst = 1'b1;
        apply(mk(0, 8'h01, 4'h0, 32'h0), mk(0, 8'h02, 4'h0, 32'h0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst gnt0", g0, 1'b0);
            chk("rst gnt1", g1, 1'b0);
            chk("rst rvalid0", rv0, 1'b0);
            chk("rst rvalid1", rv1, 1'b0);
            step();
        end
        rst = 1'b0;
        prev = -1;
        for (int c = 0; c < 6; c++) begin
            logic exp1;
`ifdef CLUSTERV_TILE_SRAM_ARB_RR_EN
            exp1 = (c % 2) == 1;
`else
            exp1 = 1'b0;
`endif
            @(negedge clk);
            chk("cont gnt0", g0, !exp1);
            chk("cont gnt1", g1, exp1);
            chk("cont rvalid0", rv0, prev == 0);
            chk("cont rvalid1", rv1, prev == 1);
            if (prev == 0) chk("cont rdata0", rd0, 32'h000000AA);
            if (prev == 1) chk("cont rdata1", rd1, 32'h12345678);
            prev = exp1 ? 1 : 0;
            step();
        end

        // i1 read granted, reset asserted the next cycle: response must vanish.
        apply(IDLE, mk(0, 8'h02, 4'h0, 32'h0));
        @(negedge clk);
        chk("abort gnt1", g1, 1'b1);
        step();
        rst = 1'b1;
        apply(IDLE, IDLE);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort rvalid1 in reset", rv1, 1'b0);
            step();
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort rvalid0 after", rv0, 1'b0);
            chk("abort rvalid1 after", rv1, 1'b0);
            step();
        end

        // i1 alone: eight back-to-back reads.
        for (int c = 0; c < 9; c++) begin
            if (c < 8) apply(IDLE, mk(0, (c % 2 == 1) ? 8'h02 : 8'h01, 4'h0, 32'h0));
            else       apply(IDLE, IDLE);
            @(negedge clk);
            chk("b2b gnt1", g1, c < 8);
            chk("b2b rvalid1", rv1, c > 0);
            if (c > 0) chk("b2b rdata1", rd1, ((c - 1) % 2 == 1) ? 32'h12345678 : 32'h000000AA);
            step();
        end

        // Randomised traffic against a transaction-level reference model.
        rst = 1'b1;
        apply(IDLE, IDLE);
        repeat (2) step();
        rst = 1'b0;
        foreach (mem[i]) shadow[i] = mem[i];
        p0 = IDLE; p1 = IDLE;
        last_m = 1'b1;
        resp_v = 1'b0; resp_own = 1'b0; resp_d = '0;
        for (int c = 0; c < 500; c++) begin
            if (!p0.req && $urandom_range(0, 2) != 0)
                p0 = mk(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), BW'($urandom), $urandom);
            if (!p1.req && $urandom_range(0, 2) != 0)
                p1 = mk(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), BW'($urandom), $urandom);
            apply(p0, p1);
            @(negedge clk);
`ifdef CLUSTERV_TILE_SRAM_ARB_RR_EN
            pref0 = last_m;
`else
            pref0 = 1'b1;
`endif
            eg0 = p0.req && (!p1.req || pref0);
            eg1 = p1.req && !eg0;
            chk("rnd gnt0", g0, eg0);
            chk("rnd gnt1", g1, eg1);
            chk("rnd rvalid0", rv0, resp_v && !resp_own);
            chk("rnd rvalid1", rv1, resp_v && resp_own);
            if (resp_v) chk("rnd rdata", resp_own ? rd1 : rd0, resp_d);
            resp_v = 1'b0;
            if (eg0 || eg1) begin
                sel = eg0 ? p0 : p1;
                last_m = eg1;
                chk("rnd t_addr", t_addr, sel.addr);
                chk("rnd t_we", t_we, sel.we);
                if (sel.we) shadow[sel.addr] = merge(shadow[sel.addr], sel.wd, sel.be);
                else begin
                    resp_v = 1'b1;
                    resp_own = eg1;
                    resp_d = shadow[sel.addr];
                end
                if (eg0) p0.req = 1'b0;
                else     p1.req = 1'b0;
            end else begin
                chk("rnd t_re idle", t_re, 1'b0);
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
